// File: rtl/kb_pkg.sv
// Shared keyboard-event definitions: controls_in PIO layout and the sys_ctrl pop bit,
// kept in one place so RTL and firmware headers agree.
package kb_pkg;

  localparam int unsigned KB_KW               = 16;
  localparam int unsigned CTRL_KEYCODE_LSB    = 0;
  localparam int unsigned CTRL_COUNT_LSB      = 16;
  localparam int unsigned CTRL_COUNT_W        = 6;
  localparam int unsigned CTRL_OVF_BIT        = 22;
  localparam int unsigned CTRL_HEAD_VALID_BIT = 23;
  localparam int unsigned SYS_CTRL_POP_BIT    = 4;

  // controls_in word as seen by the CPU (bit 0 = keycode LSB)
  typedef struct packed {
    logic [7:0]              rsvd;
    logic                    head_valid;
    logic                    overflow;
    logic [CTRL_COUNT_W-1:0] count;
    logic [KB_KW-1:0]        keycode;
  } controls_in_t;

  function automatic controls_in_t pack_controls(input logic [KB_KW-1:0]        kc,
                                                 input logic [CTRL_COUNT_W-1:0] cnt,
                                                 input logic                    ovf,
                                                 input logic                    hv);
    controls_in_t w;
    w            = '0;
    w.keycode    = kc;
    w.count      = cnt;
    w.overflow   = ovf;
    w.head_valid = hv;
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with async active-low reset.
module sync_2ff (
  input  logic clk27,
  input  logic po_reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk27 or negedge po_reset_n) begin
    if (!po_reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/kb_event_fifo.sv
// Keycode event FIFO between the keyboard path and the CPU controls_in PIO.
// One push per kc_valid_in rising edge, one pop per pop_toggle level change.
module kb_event_fifo
  import kb_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned KW    = KB_KW,
  parameter int unsigned CW    = 4
) (
  input  logic          clk27,
  input  logic          po_reset_n,
  input  logic          kc_valid_in,
  input  logic [KW-1:0] kc_in,
  input  logic          pop_toggle,
  input  logic          ovf_clear,
  output logic [KW-1:0] head_keycode,
  output logic          head_valid,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic          v2, v3;
  logic          pop_prev, init_done;
  logic [AW-1:0] rptr, wptr;
  logic [KW-1:0] mem [DEPTH];

  logic          push_c, pop_c, full_c, empty_c;
  logic          push_acc_c, pop_acc_c, drop_c;
  logic [AW-1:0] rptr_n_c, wptr_n_c;
  logic [CW-1:0] count_n_c;
  logic          ovf_n_c;
  logic [KW-1:0] head_n_c;

  sync_2ff u_sync_valid (
    .clk27      (clk27),
    .po_reset_n (po_reset_n),
    .d          (kc_valid_in),
    .q          (v2)
  );

  // Next-state: pop is applied before push, so a push into a full FIFO with a pop is kept
  always_comb begin
    push_c     = v2 & ~v3;
    pop_c      = init_done & (pop_toggle != pop_prev);
    full_c     = (count == CW'(DEPTH));
    empty_c    = (count == '0);
    pop_acc_c  = pop_c & ~empty_c;
    push_acc_c = push_c & (~full_c | pop_acc_c);
    drop_c     = push_c & ~push_acc_c;
    rptr_n_c   = rptr + AW'(pop_acc_c);
    wptr_n_c   = wptr + AW'(push_acc_c);
    count_n_c  = count + CW'(push_acc_c) - CW'(pop_acc_c);
    ovf_n_c    = ovf_clear ? 1'b0 : (overflow | drop_c);
    // Bypass when the new head is the slot being written this cycle
    head_n_c   = (push_acc_c && (rptr_n_c == wptr)) ? kc_in : mem[rptr_n_c];
  end

  always_ff @(posedge clk27 or negedge po_reset_n) begin
    if (!po_reset_n) begin
      v3           <= 1'b0;
      pop_prev     <= 1'b0;
      init_done    <= 1'b0;
      rptr         <= '0;
      wptr         <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      head_valid   <= 1'b0;
      head_keycode <= '0;
    end else begin
      v3         <= v2;
      pop_prev   <= pop_toggle;
      init_done  <= 1'b1;
      rptr       <= rptr_n_c;
      wptr       <= wptr_n_c;
      count      <= count_n_c;
      overflow   <= ovf_n_c;
      head_valid <= (count_n_c != '0);
      if (count_n_c != '0) begin
        head_keycode <= head_n_c;
      end
    end
  end

  // Storage carries no reset; unread slots are never exposed
  always_ff @(posedge clk27) begin
    if (push_acc_c) begin
      mem[wptr] <= kc_in;
    end
  end

endmodule

// File: tb/tb_kb_event_fifo.sv
// Directed bench for kb_event_fifo with a keycode scoreboard queue.
module tb_kb_event_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned KW    = 16;
  localparam int unsigned CW    = 4;

  logic          clk27 = 1'b0;
  logic          po_reset_n;
  logic          kc_valid_in;
  logic [KW-1:0] kc_in;
  logic          pop_toggle;
  logic          ovf_clear;
  logic [KW-1:0] head_keycode;
  logic          head_valid;
  logic [CW-1:0] count;
  logic          overflow;

  int            checks = 0;
  int            errors = 0;
  logic [KW-1:0] sb [$];

  always #5 clk27 = ~clk27;

  kb_event_fifo #(.DEPTH(DEPTH), .KW(KW), .CW(CW)) dut (
    .clk27        (clk27),
    .po_reset_n   (po_reset_n),
    .kc_valid_in  (kc_valid_in),
    .kc_in        (kc_in),
    .pop_toggle   (pop_toggle),
    .ovf_clear    (ovf_clear),
    .head_keycode (head_keycode),
    .head_valid   (head_valid),
    .count        (count),
    .overflow     (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full keycode event: kc_in stable one period before the strobe, strobe high 6 periods
  task automatic send_event(input logic [KW-1:0] kc, input bit accepted);
    @(negedge clk27);
    kc_in = kc;
    @(negedge clk27);
    kc_valid_in = 1'b1;
    repeat (6) @(negedge clk27);
    kc_valid_in = 1'b0;
    repeat (3) @(negedge clk27);
    if (accepted) sb.push_back(kc);
  endtask

  // Check the head against the scoreboard, then pop it
  task automatic pop_check(input string tag);
    logic [KW-1:0] exp;
    exp = '0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      exp = sb.pop_front();
    end
    chk({tag, "_hv"}, 32'(head_valid), 32'd1);
    chk({tag, "_kc"}, 32'(head_keycode), 32'(exp));
    pop_toggle = ~pop_toggle;
    repeat (2) @(negedge clk27);
  endtask

  initial begin
    po_reset_n  = 1'b0;
    kc_valid_in = 1'b0;
    kc_in       = '0;
    pop_toggle  = 1'b0;
    ovf_clear   = 1'b0;
    repeat (3) @(negedge clk27);
    chk("rst_hv", 32'(head_valid), 32'd0);
    chk("rst_kc", 32'(head_keycode), 32'd0);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    po_reset_n = 1'b1;
    repeat (2) @(negedge clk27);

    // 1: single event latency and pop
    kc_in = 16'h1A2B;
    @(negedge clk27);
    kc_valid_in = 1'b1;
    repeat (4) @(posedge clk27);
    #1;
    chk("t1_hv", 32'(head_valid), 32'd1);
    chk("t1_kc", 32'(head_keycode), 32'h1A2B);
    chk("t1_cnt", 32'(count), 32'd1);
    @(negedge clk27);
    @(negedge clk27);
    kc_valid_in = 1'b0;
    repeat (3) @(negedge clk27);
    sb.push_back(16'h1A2B);
    pop_check("t1_pop");
    chk("t1_hv_after", 32'(head_valid), 32'd0);
    chk("t1_cnt_after", 32'(count), 32'd0);
    chk("t1_kc_hold", 32'(head_keycode), 32'h1A2B);

    // 2: fill, overflow on the 9th, drain in order
    for (int i = 1; i <= 8; i++) send_event(KW'(i), 1'b1);
    chk("t2_cnt8", 32'(count), 32'd8);
    chk("t2_ovf0", 32'(overflow), 32'd0);
    send_event(16'h0009, 1'b0);
    chk("t2_cnt_full", 32'(count), 32'd8);
    chk("t2_ovf1", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) pop_check("t2_pop");
    chk("t2_cnt_empty", 32'(count), 32'd0);
    chk("t2_hv_empty", 32'(head_valid), 32'd0);
    chk("t2_ovf_sticky", 32'(overflow), 32'd1);
    ovf_clear = 1'b1;
    @(negedge clk27);
    ovf_clear = 1'b0;
    @(negedge clk27);
    chk("t2_ovf_clr", 32'(overflow), 32'd0);

    // 3: full FIFO, push and pop land in the same cycle
    for (int i = 0; i < 8; i++) send_event(16'h0011 + KW'(i), 1'b1);
    chk("t3_cnt8", 32'(count), 32'd8);
    kc_in = 16'h0099;
    @(negedge clk27);
    kc_valid_in = 1'b1;
    repeat (2) @(negedge clk27);
    pop_check("t3_coinc");
    sb.push_back(16'h0099);
    repeat (2) @(negedge clk27);
    kc_valid_in = 1'b0;
    repeat (3) @(negedge clk27);
    chk("t3_cnt_keep", 32'(count), 32'd8);
    chk("t3_ovf_keep", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) pop_check("t3_pop");
    chk("t3_cnt_empty", 32'(count), 32'd0);

    // 4: pop_toggle high across reset release must not pop
    po_reset_n = 1'b0;
    pop_toggle = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk27);
    po_reset_n = 1'b1;
    repeat (3) @(negedge clk27);
    chk("t4_cnt0", 32'(count), 32'd0);
    send_event(16'h00FF, 1'b1);
    chk("t4_cnt1", 32'(count), 32'd1);
    pop_check("t4_pop");

    // 5: pops on empty are ignored
    for (int i = 0; i < 3; i++) begin
      pop_toggle = ~pop_toggle;
      repeat (2) @(negedge clk27);
      chk("t5_empty_cnt", 32'(count), 32'd0);
    end
    send_event(16'h5555, 1'b1);
    chk("t5_cnt1", 32'(count), 32'd1);
    pop_check("t5_pop");

    // 5b: ovf_clear beats a same-cycle dropped push
    for (int i = 0; i < 8; i++) send_event(16'h0021 + KW'(i), 1'b1);
    send_event(16'h0029, 1'b0);
    chk("t5_ovf_set", 32'(overflow), 32'd1);
    kc_in = 16'h002A;
    @(negedge clk27);
    kc_valid_in = 1'b1;
    repeat (2) @(negedge clk27);
    ovf_clear = 1'b1;
    @(negedge clk27);
    ovf_clear = 1'b0;
    repeat (3) @(negedge clk27);
    kc_valid_in = 1'b0;
    repeat (3) @(negedge clk27);
    chk("t5_ovf_prio", 32'(overflow), 32'd0);
    chk("t5_cnt_full", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) pop_check("t5_drain");

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) send_event(16'h0031 + KW'(i), 1'b1);
    chk("t6_cnt5", 32'(count), 32'd5);
    #2;
    po_reset_n = 1'b0;
    #1;
    chk("t6_hv", 32'(head_valid), 32'd0);
    chk("t6_kc", 32'(head_keycode), 32'd0);
    chk("t6_cnt", 32'(count), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    sb.delete();
    @(negedge clk27);
    po_reset_n = 1'b1;
    repeat (2) @(negedge clk27);
    send_event(16'hBEEF, 1'b1);
    chk("t6_cnt1", 32'(count), 32'd1);
    pop_check("t6_pop");
    chk("t6_cnt_end", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kb_event_fifo.md
Name: kb_event_fifo

Overview:
- Queues keycode events from the NeXT keyboard path and hands them one at a time to the CPU over the 32-bit controls_in PIO.
- Replaces the single overwrite-prone keycode latch: no event is lost while the CPU is slow, up to DEPTH entries.
- The CPU pops an entry by toggling a sys_ctrl bit. The block is clocked on clk27 and sits between NextSoundBox and sys_inst.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of 2, 2..32
- KW, 16, keycode width in bits
- CW, 4, count width; must equal log2(DEPTH)+1

Ports:
- clk27  in  1  system clock, 27 MHz
- po_reset_n  in  1  reset: asynchronous, active-low
- kc_valid_in  in  1  keycode strobe, asynchronous to clk27; high level for >=4 clk27 periods per event
- kc_in  in  KW  keycode; stable from 1 clk27 period before the kc_valid_in rise until kc_valid_in falls
- pop_toggle  in  1  CPU pop request (sys_ctrl bit); every level change = one pop
- ovf_clear  in  1  synchronous clear of the overflow flag, level
- head_keycode  out  KW  oldest queued keycode, registered
- head_valid  out  1  FIFO not empty
- count  out  CW  number of queued entries, 0..DEPTH
- overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset values: head_keycode=0, head_valid=0, count=0, overflow=0; read pointer, write pointer, synchronizers, pop_prev and init_done all 0.
- Reset is asynchronous: asserting it mid-operation flushes all entries immediately.
- Input synchronizer: kc_valid_in goes through 2 flops (v1, v2) and a delay flop v3.
- push = v2 & ~v3, i.e. one pulse per rising edge.
- kc_in is sampled directly into mem[wptr] on the push cycle. This is legal only because of the stability contract on kc_in; there is no multi-bit synchronizer.
- Pop detect: pop = init_done & (pop_toggle != pop_prev); pop_prev <= pop_toggle every cycle.
  - init_done is set on the first clock after reset.
  - Consequence: a pop_toggle level present at reset release never causes a pop.
- Pointer and count rules, evaluated each cycle:
  - push & ~full: write mem[wptr], wptr+1 (wraps mod DEPTH)
  - push & full & ~pop: entry dropped, overflow<=1, pointers unchanged
  - push & full & pop: pop first, then write; count stays DEPTH; no overflow
  - pop & empty: ignored, no pointer change, no error flag
  - pop & ~empty: rptr+1 (wraps mod DEPTH)
  - count <= count + (push accepted) - (pop accepted)
- Overflow flag:
  - ovf_clear has priority over a same-cycle overflow set; that dropped event is not flagged.
  - The flag stays set until ovf_clear is asserted.
- Output registers, updated each cycle from the next-state values:
  - head_valid <= (next count != 0)
  - head_keycode <= mem[next rptr], or the incoming kc_in when writing into an empty FIFO (bypass)
  - Outputs change no earlier than the cycle after the cause.
- Latency, empty FIFO: kc_valid_in rise -> head_valid=1 after at most 4 clk27 edges (2 sync + edge detect + output register).
- Latency, pop: toggle change -> updated head/count after 2 edges.
- Empty-after-pop: head_valid<=0; head_keycode holds its last value (not cleared).
- No state machine beyond init_done and the pointers; no combinational path from any input to any output.

Decomposition:
- Shared package kb_pkg: KW default, the controls_in bit-field positions (keycode[15:0], count, overflow, head_valid), and the sys_ctrl pop bit index, so the top level and firmware headers agree.
- One natural sub-module, sync_2ff: single-bit 2-flop synchronizer with async reset. Reuse it for kc_valid_in; it is also usable for the existing button/IR sync chains.
- Memory is a plain register array; no vendor RAM inference required at DEPTH<=32.

Test Plan:
1. Reset, then one event kc_in=16'h1A2B with kc_valid_in high for 6 cycles -> within 4 edges head_valid=1, head_keycode=16'h1A2B, count=1; after one pop_toggle flip, 2 edges later head_valid=0, count=0.
2. Push 8 events 16'h0001..16'h0008, then a 9th 16'h0009 -> count=8, overflow=1. Pop 8 times -> heads read in order 0001..0008, never 0009.
3. FIFO full (8 entries) and push coinciding with pop in the same cycle -> count stays 8, overflow stays 0, last entry read back = pushed value.
4. Hold pop_toggle=1 through reset release with FIFO empty, then push 16'h00FF -> no spurious pop; head=16'h00FF, count=1.
5. Pop on empty FIFO (3 toggles) -> count=0, no pointer corruption; a following push of 16'h5555 reads back correctly. Set overflow, then assert ovf_clear in the same cycle as a dropped push -> overflow=0.
6. Assert po_reset_n low mid-stream with count=5 -> all outputs 0 immediately (asynchronously). After release, a new event 16'hBEEF appears as the head.
